exhaustive_func_checker: RTL
============================

Name: exhaustive_func_checker

Overview:
- Exhaustive stimulus driver and response checker for a small combinational gate-level unit, such as the 3-input f = a·b + a·c·b' lab circuit.
- On start, it walks every input vector, drives it onto the unit, waits a programmable settle time to cover gate delays, then samples the unit's output.
- Each sample is compared against a parameterised truth table; the block reports pass/fail, the mismatch count and the first failing vector.
- Sits beside the unit under test in lab top-levels and on-board self-test wrappers.

Parameters:
- N_IN, 3, number of inputs of the unit under test (1..6).
- TRUTH, 8'b1110_0000, expected output per vector; bit i = expected f for dut_in == i. Width 2**N_IN. Default encodes f = a(b+c) with dut_in = {a,b,c}.
- SETTLE_CYCLES, 4, clock cycles waited after driving a vector before sampling (1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- dut_in  out  N_IN  registered vector driven to the unit; MSB = first input (a).
- dut_out  in  1  unit output; treated as stable only after the settle window.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  level; high in DONE until the next accepted start or reset.
- pass  out  1  valid while done; 1 iff err_count == 0.
- err_count  out  N_IN+1  number of mismatching vectors in the last run.
- first_fail_vec  out  N_IN  first mismatching vector; 0 if none.
- first_fail_valid  out  1  set at the first mismatch of a run.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid.
- State encoding: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 → DRIVE.
  - In the same edge: vector counter=0, err_count=0, first_fail_valid=0, first_fail_vec=0, done=0, pass=0, busy=1.
- DRIVE (1 cycle): dut_in <= vector counter; settle counter <= SETTLE_CYCLES-1; → SETTLE.
- SETTLE: decrement each cycle; at 0 → SAMPLE. Occupies exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): compare dut_out with TRUTH[vector].
  - On mismatch: err_count++ (saturating at 2**N_IN, which cannot be exceeded).
  - On mismatch with first_fail_valid=0: capture first_fail_vec=vector and set first_fail_valid=1.
  - If vector == 2**N_IN-1: → DONE. Otherwise vector++ and → DRIVE.
- DONE: busy=0, done=1, pass=(err_count==0). dut_in holds the last vector.
  - start=1 → restart as from IDLE, with identical clearing.
- Timing: each vector takes SETTLE_CYCLES+2 cycles, so a run takes 2**N_IN·(SETTLE_CYCLES+2) cycles from the accept edge to done rising.
- start while busy is ignored, with no effect on counters.
- The vector counter is N_IN+1 bits wide so the terminal compare does not wrap.
- rst mid-run aborts immediately to the reset state; no partial result is retained.
- dut_out is sampled only in SAMPLE; glitches during SETTLE have no effect.

Optional Feature:
- Macro STOP_ON_FAIL_EN.
- When defined: a mismatch in SAMPLE goes directly to DONE with pass=0, err_count=1 and first_fail_vec captured. The remaining vectors are skipped, and dut_in holds the failing vector for probing.
- When undefined: every vector is always exercised, as described in Behaviour.

Decomposition:
- Shared package: the state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE) and a localparam default truth table for the lab circuit, F_ABC_TRUTH = 8'b1110_0000.
- One sub-module, settle_timer:
  - Loadable down-counter, 8 bits.
  - Inputs: load, load_value, enable.
  - Output: expired.
  - Instantiated once by the FSM.

Test Plan:
- Correct DUT model (f=a&(b|c)), SETTLE_CYCLES=4, pulse start → done rises 48 cycles after accept; pass=1, err_count=0, first_fail_valid=0.
- Faulty DUT f=a&b → done with pass=0, err_count=1, first_fail_vec=3'b101, first_fail_valid=1.
- DUT stuck-at-1 → err_count=5 (vectors 0..4 mismatch), first_fail_vec=3'b000; dut_in sequence observed as 0,1,…,7 at DRIVE+1.
- DUT with 30 ns propagation and 10 ns clock, SETTLE_CYCLES=4 → pass=1. With SETTLE_CYCLES=1 → pass=0, proving the settle window is honoured.
- Assert rst at cycle 20 of a run → all outputs 0 within the same cycle (async); a later start runs a full 48-cycle run. Start pulses while busy have no effect on err_count or timing.
- STOP_ON_FAIL_EN defined, stuck-at-1 DUT → done after 6 cycles, err_count=1, first_fail_vec=3'b000, dut_in=3'b000.

Source files
------------

// File: rtl/exhaustive_func_checker_pkg.sv
// Shared types and constants for the exhaustive combinational-unit checker.
package exhaustive_func_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // Lab circuit f = a(b+c) with dut_in = {a,b,c}; bit i is f for dut_in == i.
    localparam logic [7:0] F_ABC_TRUTH = 8'b1110_0000;

endpackage

// File: rtl/exhaustive_func_checker_if.sv
// Control/status and unit-under-test signals of the exhaustive checker.
interface exhaustive_func_checker_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail_vec;
    logic            first_fail_valid;

    // The checker masters the unit: it drives vectors and reports results.
    modport master (
        input  start, dut_out,
        output dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        output start, dut_out,
        input  dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/exhaustive_func_checker_settle_timer.sv
// Loadable 8-bit down-counter timing the settle window after each vector.
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       enable,
    output logic       expired
);
    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign expired = (count == 8'd0);
endmodule

// File: rtl/exhaustive_func_checker.sv
// Walks every input vector of a small combinational unit and checks it against TRUTH.
// Define STOP_ON_FAIL_EN to end a run at the first mismatching vector.
module exhaustive_func_checker
    import exhaustive_func_checker_pkg::*;
#(
    parameter int                 N_IN          = 3,
    parameter logic [2**N_IN-1:0] TRUTH         = F_ABC_TRUTH,
    parameter int                 SETTLE_CYCLES = 4
) (
    input logic                       clk,
    input logic                       rst,
    exhaustive_func_checker_if.master bus
);
    localparam int               CNT_W       = N_IN + 1;
    localparam logic [CNT_W-1:0] LAST_VEC    = CNT_W'((2**N_IN) - 1);
    localparam logic [CNT_W-1:0] ERR_MAX     = CNT_W'(2**N_IN);
    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t state, state_next;

    // One extra bit so the terminal compare against 2**N_IN-1 never wraps.
    logic [CNT_W-1:0] vec;
    logic [N_IN-1:0]  dut_in_q;
    logic [CNT_W-1:0] err_q;
    logic [N_IN-1:0]  ffvec_q;
    logic             ffvalid_q;
    logic             busy_q, done_q, pass_q;

    logic timer_load, timer_en, timer_expired;
    logic accept, mismatch, last_vec, stop_now;

    settle_timer u_settle_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_value(SETTLE_LOAD),
        .enable    (timer_en),
        .expired   (timer_expired)
    );

    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign mismatch = (state == SAMPLE) && (bus.dut_out != TRUTH[vec[N_IN-1:0]]);
    assign last_vec = (vec == LAST_VEC);

`ifdef STOP_ON_FAIL_EN
    assign stop_now = last_vec || mismatch;
`else
    assign stop_now = last_vec;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        unique case (state)
            IDLE, DONE: if (bus.start) state_next = DRIVE;
            DRIVE: begin
                timer_load = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                if (timer_expired) state_next = SAMPLE;
                else               timer_en   = 1'b1;
            end
            SAMPLE:  state_next = stop_now ? DONE : DRIVE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every flop has an async reset value, so an aborted run leaves no partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec       <= '0;
            dut_in_q  <= '0;
            err_q     <= '0;
            ffvec_q   <= '0;
            ffvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            if (accept) begin
                vec       <= '0;
                err_q     <= '0;
                ffvec_q   <= '0;
                ffvalid_q <= 1'b0;
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
                pass_q    <= 1'b0;
            end
            if (state == DRIVE) dut_in_q <= vec[N_IN-1:0];
            if (state == SAMPLE) begin
                if (mismatch && err_q != ERR_MAX) err_q <= err_q + 1'b1;
                if (mismatch && !ffvalid_q) begin
                    ffvec_q   <= vec[N_IN-1:0];
                    ffvalid_q <= 1'b1;
                end
                if (stop_now) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (err_q == '0) && !mismatch;
                end else begin
                    vec <= vec + 1'b1;
                end
            end
        end
    end

    assign bus.dut_in           = dut_in_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ffvec_q;
    assign bus.first_fail_valid = ffvalid_q;
endmodule
